// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I core: sequences ALU, memory port, register file
// and immediate extender one instruction at a time.
module multicycle_controller (
    input  logic       clk,
    input  logic       reset,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic [2:0] immsrc,
    output logic [1:0] alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] resultsrc,
    output logic       adrsrc,
    output logic [2:0] alucontrol,
    output logic       irwrite,
    output logic       pcwrite,
    output logic       regwrite,
    output logic       memwrite,
    output logic       retire,
    output logic       illegal
);

    localparam logic [3:0] StFetch    = 4'd0;
    localparam logic [3:0] StDecode   = 4'd1;
    localparam logic [3:0] StMemAdr   = 4'd2;
    localparam logic [3:0] StMemRead  = 4'd3;
    localparam logic [3:0] StMemWb    = 4'd4;
    localparam logic [3:0] StMemWrite = 4'd5;
    localparam logic [3:0] StExecR    = 4'd6;
    localparam logic [3:0] StExecI    = 4'd7;
    localparam logic [3:0] StExecU    = 4'd8;
    localparam logic [3:0] StAluWb    = 4'd9;
    localparam logic [3:0] StJalrAdr  = 4'd10;
    localparam logic [3:0] StJal      = 4'd11;
    localparam logic [3:0] StBranch   = 4'd12;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpAluImm = 7'b0010011;
    localparam logic [6:0] OpAuipc  = 7'b0010111;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpReg    = 7'b0110011;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpJal    = 7'b1101111;

    localparam logic [2:0] AluAdd = 3'b000;
    localparam logic [2:0] AluSub = 3'b001;
    localparam logic [2:0] AluAnd = 3'b010;
    localparam logic [2:0] AluOr  = 3'b011;
    localparam logic [2:0] AluSlt = 3'b101;

    logic [3:0] state_q, state_d, cur;
    logic [2:0] funct_alu;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        unique case (op)
            OpLoad, OpAluImm, OpJalr: immsrc = 3'b000;
            OpStore:                  immsrc = 3'b001;
            OpBranch:                 immsrc = 3'b010;
            OpJal:                    immsrc = 3'b011;
            OpLui, OpAuipc:           immsrc = 3'b100;
            default:                  immsrc = 3'b000;
        endcase
    end

    // Subtract only for R-type; I-type funct7b5 is immediate bits, not an opcode modifier.
    always_comb begin
        unique case (funct3)
            3'b000:  funct_alu = (op[5] & funct7b5) ? AluSub : AluAdd;
            3'b010:  funct_alu = AluSlt;
            3'b110:  funct_alu = AluOr;
            3'b111:  funct_alu = AluAnd;
            default: funct_alu = AluAdd;
        endcase
    end

    // During reset the outputs present FETCH selects with every enable suppressed.
    assign cur = reset ? StFetch : state_q;

    always_comb begin
        state_d    = StFetch;
        alusrca    = 2'b00;
        alusrcb    = 2'b00;
        resultsrc  = 2'b00;
        adrsrc     = 1'b0;
        alucontrol = AluAdd;
        irwrite    = 1'b0;
        pcwrite    = 1'b0;
        regwrite   = 1'b0;
        memwrite   = 1'b0;
        retire     = 1'b0;
        illegal    = 1'b0;
        case (cur)
            StFetch: begin
                irwrite   = 1'b1;
                alusrcb   = 2'b10;
                resultsrc = 2'b10;
                pcwrite   = 1'b1;
                state_d   = StDecode;
            end
            StDecode: begin
                alusrca = 2'b01;
                alusrcb = 2'b01;
                case (op)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpReg:           state_d = StExecR;
                    OpAluImm:        state_d = StExecI;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalrAdr;
                    OpLui, OpAuipc:  state_d = StExecU;
                    OpBranch: begin
                        if (funct3[2:1] == 2'b00) begin
                            state_d = StBranch;
                        end else begin
                            illegal = 1'b1;
                        end
                    end
                    default: illegal = 1'b1;
                endcase
            end
            StMemAdr: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = op[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                adrsrc  = 1'b1;
                state_d = StMemWb;
            end
            StMemWb: begin
                resultsrc = 2'b01;
                regwrite  = 1'b1;
                retire    = 1'b1;
            end
            StMemWrite: begin
                adrsrc   = 1'b1;
                memwrite = 1'b1;
                retire   = 1'b1;
            end
            StExecR: begin
                alusrca    = 2'b10;
                alucontrol = funct_alu;
                state_d    = StAluWb;
            end
            StExecI: begin
                alusrca    = 2'b10;
                alusrcb    = 2'b01;
                alucontrol = funct_alu;
                state_d    = StAluWb;
            end
            StExecU: begin
                alusrca = op[5] ? 2'b11 : 2'b01;
                alusrcb = 2'b01;
                state_d = StAluWb;
            end
            StAluWb: begin
                regwrite = 1'b1;
                retire   = 1'b1;
            end
            StJalrAdr: begin
                alusrca = 2'b10;
                alusrcb = 2'b01;
                state_d = StJal;
            end
            StJal: begin
                alusrca = 2'b01;
                alusrcb = 2'b10;
                pcwrite = 1'b1;
                state_d = StAluWb;
            end
            StBranch: begin
                alusrca    = 2'b10;
                alucontrol = AluSub;
                pcwrite    = funct3[0] ? ~zero : zero;
                retire     = 1'b1;
            end
            default: state_d = StFetch;
        endcase
        if (reset) begin
            irwrite  = 1'b0;
            pcwrite  = 1'b0;
            regwrite = 1'b0;
            memwrite = 1'b0;
            retire   = 1'b0;
            illegal  = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class cycle by cycle
// and compares the packed control word against hand-computed values.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic [2:0] immsrc;
    logic [1:0] alusrca, alusrcb, resultsrc;
    logic       adrsrc;
    logic [2:0] alucontrol;
    logic       irwrite, pcwrite, regwrite, memwrite, retire, illegal;

    int checks = 0;
    int errors = 0;

    multicycle_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .immsrc     (immsrc),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .resultsrc  (resultsrc),
        .adrsrc     (adrsrc),
        .alucontrol (alucontrol),
        .irwrite    (irwrite),
        .pcwrite    (pcwrite),
        .regwrite   (regwrite),
        .memwrite   (memwrite),
        .retire     (retire),
        .illegal    (illegal)
    );

    always #5 clk = ~clk;

    // Packed word: {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
    //               irwrite, pcwrite, regwrite, memwrite, retire, illegal}
    logic [18:0] outs;
    assign outs = {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
                   irwrite, pcwrite, regwrite, memwrite, retire, illegal};

    function automatic logic [18:0] ov(input logic [2:0] imm, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] rs,
                                       input logic adr, input logic [2:0] alu,
                                       input logic [5:0] en);
        return {imm, a, b, rs, adr, alu, en};
    endfunction

    function automatic logic [18:0] fetch_v(input logic [2:0] imm);
        return ov(imm, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 6'b110000);
    endfunction

    function automatic logic [18:0] dec_v(input logic [2:0] imm);
        return ov(imm, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000000);
    endfunction

    function automatic logic [18:0] aluwb_v(input logic [2:0] imm);
        return ov(imm, 2'b00, 2'b00, 2'b00, 1'b0, 3'b000, 6'b001010);
    endfunction

    task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    // Called just after a rising edge; samples on the falling edge, returns after the next rise.
    task automatic step(input string tag, input logic [18:0] exp);
        @(negedge clk);
        check(tag, outs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input logic z);
        op       = o;
        funct3   = f3;
        funct7b5 = f7;
        zero     = z;
    endtask

    initial begin
        reset = 1'b1;
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        step("rst_a", ov(3'b000, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 6'b000000));
        reset = 1'b0;

        // lw
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0);
        step("lw_fetch", fetch_v(3'b000));
        step("lw_dec",   dec_v(3'b000));
        step("lw_madr",  ov(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000000));
        step("lw_mrd",   ov(3'b000, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 6'b000000));
        step("lw_wb",    ov(3'b000, 2'b00, 2'b00, 2'b01, 1'b0, 3'b000, 6'b001010));

        // sw
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0);
        step("sw_fetch", fetch_v(3'b001));
        step("sw_dec",   dec_v(3'b001));
        step("sw_madr",  ov(3'b001, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000000));
        step("sw_mwr",   ov(3'b001, 2'b00, 2'b00, 2'b00, 1'b1, 3'b000, 6'b000110));

        // sub
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        step("sub_fetch", fetch_v(3'b000));
        step("sub_dec",   dec_v(3'b000));
        step("sub_exec",  ov(3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 6'b000000));
        step("sub_wb",    aluwb_v(3'b000));

        // slt
        set_instr(7'b0110011, 3'b010, 1'b0, 1'b0);
        step("slt_fetch", fetch_v(3'b000));
        step("slt_dec",   dec_v(3'b000));
        step("slt_exec",  ov(3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 3'b101, 6'b000000));
        step("slt_wb",    aluwb_v(3'b000));

        // addi with funct7b5 set must still add; ori checks the or decode
        set_instr(7'b0010011, 3'b000, 1'b1, 1'b0);
        step("addi_fetch", fetch_v(3'b000));
        step("addi_dec",   dec_v(3'b000));
        step("addi_exec",  ov(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000000));
        step("addi_wb",    aluwb_v(3'b000));
        set_instr(7'b0010011, 3'b110, 1'b0, 1'b0);
        step("ori_fetch", fetch_v(3'b000));
        step("ori_dec",   dec_v(3'b000));
        step("ori_exec",  ov(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 3'b011, 6'b000000));
        step("ori_wb",    aluwb_v(3'b000));

        // beq taken / not taken, bne not-equal
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b1);
        step("beq1_fetch", fetch_v(3'b010));
        step("beq1_dec",   dec_v(3'b010));
        step("beq1_br",    ov(3'b010, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 6'b010010));
        set_instr(7'b1100011, 3'b000, 1'b0, 1'b0);
        step("beq0_fetch", fetch_v(3'b010));
        step("beq0_dec",   dec_v(3'b010));
        step("beq0_br",    ov(3'b010, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 6'b000010));
        set_instr(7'b1100011, 3'b001, 1'b0, 1'b0);
        step("bne0_fetch", fetch_v(3'b010));
        step("bne0_dec",   dec_v(3'b010));
        step("bne0_br",    ov(3'b010, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 6'b010010));
        set_instr(7'b1100011, 3'b001, 1'b0, 1'b1);
        step("bne1_fetch", fetch_v(3'b010));
        step("bne1_dec",   dec_v(3'b010));
        step("bne1_br",    ov(3'b010, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 6'b000010));

        // blt is unsupported: illegal in DECODE
        set_instr(7'b1100011, 3'b100, 1'b0, 1'b1);
        step("blt_fetch", fetch_v(3'b010));
        step("blt_dec",   ov(3'b010, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000001));

        // jal
        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0);
        step("jal_fetch", fetch_v(3'b011));
        step("jal_dec",   dec_v(3'b011));
        step("jal_jal",   ov(3'b011, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 6'b010000));
        step("jal_wb",    aluwb_v(3'b011));

        // jalr
        set_instr(7'b1100111, 3'b000, 1'b0, 1'b0);
        step("jalr_fetch", fetch_v(3'b000));
        step("jalr_dec",   dec_v(3'b000));
        step("jalr_adr",   ov(3'b000, 2'b10, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000000));
        step("jalr_jal",   ov(3'b000, 2'b01, 2'b10, 2'b00, 1'b0, 3'b000, 6'b010000));
        step("jalr_wb",    aluwb_v(3'b000));

        // lui / auipc
        set_instr(7'b0110111, 3'b000, 1'b0, 1'b0);
        step("lui_fetch", fetch_v(3'b100));
        step("lui_dec",   dec_v(3'b100));
        step("lui_exec",  ov(3'b100, 2'b11, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000000));
        step("lui_wb",    aluwb_v(3'b100));
        set_instr(7'b0010111, 3'b000, 1'b0, 1'b0);
        step("auipc_fetch", fetch_v(3'b100));
        step("auipc_dec",   dec_v(3'b100));
        step("auipc_exec",  ov(3'b100, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000000));
        step("auipc_wb",    aluwb_v(3'b100));

        // illegal opcode 0000000
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0);
        step("ill_fetch", fetch_v(3'b000));
        step("ill_dec",   ov(3'b000, 2'b01, 2'b01, 2'b00, 1'b0, 3'b000, 6'b000001));

        // reset held 3 cycles in the middle of EXECUTER
        set_instr(7'b0110011, 3'b000, 1'b1, 1'b0);
        step("rr_fetch", fetch_v(3'b000));
        step("rr_dec",   dec_v(3'b000));
        reset = 1'b1;
        step("rr_rst1", ov(3'b000, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 6'b000000));
        step("rr_rst2", ov(3'b000, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 6'b000000));
        step("rr_rst3", ov(3'b000, 2'b00, 2'b10, 2'b10, 1'b0, 3'b000, 6'b000000));
        reset = 1'b0;
        step("rr_fetch2", fetch_v(3'b000));
        step("rr_dec2",   dec_v(3'b000));
        step("rr_exec",   ov(3'b000, 2'b10, 2'b00, 2'b00, 1'b0, 3'b001, 6'b000000));
        step("rr_wb",     aluwb_v(3'b000));
        step("rr_next",   fetch_v(3'b000));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
